mc_ctrl: RTL

Multicycle control sequencer for the MIPS datapath. It replaces the combinational single-cycle decoder with an FSM that issues per-state control signals to the PC, IR, register file, ALU, extender and a shared instruction/data memory port. Memory accesses use a req/ready handshake so that wait-state memories are supported. It sits between the instruction register output (Op/Funct) and the datapath muxes and write enables.

---
 rtl/mc_ctrl_if.sv | 37 +++
 rtl/mc_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - control/status bundle between the multicycle sequencer and the MIPS datapath
interface mc_ctrl_if #(
    parameter int ALUOP_W = 4,
    parameter int STATE_W = 3
);
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic [1:0]         NPCOp;
    logic               RegWrite;
    logic [1:0]         GPRSel;
    logic [1:0]         WDSel;
    logic               EXTOp;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOp;
    logic               illegal;
    logic               instr_done;
    logic [STATE_W-1:0] state;

    modport master (
        input  Op, Funct, Zero, mem_ready,
        output mem_req, mem_we, IorD, IRWrite, PCWrite, NPCOp, RegWrite,
               GPRSel, WDSel, EXTOp, ALUSrc, ALUOp, illegal, instr_done, state
    );

    modport slave (
        output Op, Funct, Zero, mem_ready,
        input  mem_req, mem_we, IorD, IRWrite, PCWrite, NPCOp, RegWrite,
               GPRSel, WDSel, EXTOp, ALUSrc, ALUOp, illegal, instr_done, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS control sequencer with req/ready memory handshake
module mc_ctrl #(
    parameter int ALUOP_W = 4,
    parameter int STATE_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_RALU, C_JR, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_JAL
    } cls_t;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    state_t     cur;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    cls_t       cls_in;
    cls_t       cls_q;
    logic [3:0] alu_op;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: return C_RALU;
                    6'h08:                             return C_JR;
                    default:                           return C_ILL;
                endcase
            end
            6'h08:   return C_ADDI;
            6'h0D:   return C_ORI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [3:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_NOP;
        endcase
    endfunction

    // DECODE judges the live IR fields; every later state uses only the latched copy.
    assign cls_in = classify(bus.Op, bus.Funct);
    assign cls_q  = classify(op_q, funct_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur     <= S_RST;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            case (cur)
                S_RST:   cur <= S_FETCH;
                S_FETCH: if (bus.mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    op_q    <= bus.Op;
                    funct_q <= bus.Funct;
                    cur     <= (cls_in == C_ILL) ? S_FETCH : S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_RALU, C_ADDI, C_ORI: cur <= S_WB;
                        C_LW, C_SW:            cur <= S_MEM;
                        default:               cur <= S_FETCH;
                    endcase
                end
                S_MEM: if (bus.mem_ready) cur <= (cls_q == C_LW) ? S_WB : S_FETCH;
                S_WB:    cur <= S_FETCH;
                default: cur <= S_RST;
            endcase
        end
    end

    // Outputs are forced low while rst is high so an aborted instruction never writes.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.IorD       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.NPCOp      = 2'b00;
        bus.RegWrite   = 1'b0;
        bus.GPRSel     = 2'd0;
        bus.WDSel      = 2'd0;
        bus.EXTOp      = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.illegal    = 1'b0;
        bus.instr_done = 1'b0;
        alu_op         = ALU_NOP;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (cls_in == C_ILL) begin
                        bus.illegal    = 1'b1;
                        bus.instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (cls_q)
                        C_RALU: alu_op = r_alu_op(funct_q);
                        C_ADDI, C_LW, C_SW: begin
                            bus.ALUSrc = 1'b1;
                            bus.EXTOp  = 1'b1;
                            alu_op     = ALU_ADD;
                        end
                        C_ORI: begin
                            bus.ALUSrc = 1'b1;
                            alu_op     = ALU_OR;
                        end
                        C_BEQ: begin
                            alu_op         = ALU_SUB;
                            bus.NPCOp      = 2'b01;
                            bus.PCWrite    = bus.Zero;
                            bus.instr_done = 1'b1;
                        end
                        C_J: begin
                            bus.NPCOp      = 2'b10;
                            bus.PCWrite    = 1'b1;
                            bus.instr_done = 1'b1;
                        end
                        C_JAL: begin
                            bus.NPCOp      = 2'b10;
                            bus.PCWrite    = 1'b1;
                            bus.RegWrite   = 1'b1;
                            bus.GPRSel     = 2'd2;
                            bus.WDSel      = 2'd2;
                            bus.instr_done = 1'b1;
                        end
                        C_JR: begin
                            bus.NPCOp      = 2'b11;
                            bus.PCWrite    = 1'b1;
                            bus.instr_done = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    bus.mem_req    = 1'b1;
                    bus.IorD       = 1'b1;
                    bus.mem_we     = (cls_q == C_SW);
                    bus.instr_done = bus.mem_ready && (cls_q == C_SW);
                end
                S_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    case (cls_q)
                        C_LW: begin
                            bus.GPRSel = 2'd1;
                            bus.WDSel  = 2'd1;
                        end
                        C_ADDI, C_ORI: bus.GPRSel = 2'd1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.ALUOp = ALUOP_W'(alu_op);
    assign bus.state = STATE_W'(cur);
endmodule
